scoreboard_register_file: RTL and testbench
===========================================

// Module: scoreboard_register_file
// PURPOSE
//   Parametrised multi-read-port register file with a per-register pending-write
//   scoreboard and same-cycle write-to-read bypass. It replaces the plain dual-port file
//   in the pipelined datapath. Issue locks a destination register, and writeback releases
//   it. Each read port reports whether its operand is still pending, so hazard logic can stall.
// PARAMETERS
//   WORDS        16               number of registers
//   BITS         32               data width
//   READ_PORTS   2                independent combinational read ports (1..4)
//   ZERO_REG     1                1: r0 reads 0, ignores writes and locks, is never busy
//   BYPASS       1                1: same-cycle write data and scoreboard release visible on reads
//   PEND_BITS    2                width of each pending counter (max 2^PEND_BITS-1 in flight)
//   ADDRESS_BITS $clog2(WORDS)    derived register address width
// PORTS
//   clk        in   1                        clock; all state updates on the rising edge
//   clr        in   1                        asynchronous reset, active-low
//   wr_en      in   1                        writeback strobe
//   wr_addr    in   ADDRESS_BITS             writeback register
//   wr_data    in   BITS                     writeback value
//   lock_en    in   1                        issue strobe: destination becomes pending
//   lock_addr  in   ADDRESS_BITS             issued destination register
//   rd_addr    in   READ_PORTS*ADDRESS_BITS  packed read addresses; port p = slice p
//   rd_data    out  READ_PORTS*BITS          packed read data
//   rd_busy    out  READ_PORTS               1: operand for port p has an outstanding write
//   lock_full  out  1                        lock_addr counter saturated (combinational)
//   lock_err   out  1                        sticky: a lock was dropped at saturation
// BEHAVIOUR
//   Reset (clr=0, async)
//   - All data registers, all pending counters and lock_err are cleared to 0.
//   - While in reset, rd_data=0 and rd_busy=0.
//   Write
//   - On posedge with wr_en, reg[wr_addr] <= wr_data.
//   - If pend[wr_addr] != 0, pend[wr_addr] decrements.
//   - A write to a register whose count is 0 is a legal unscoreboarded write; the count
//     stays 0 and does not underflow.
//   Lock
//   - On posedge with lock_en, pend[lock_addr] increments.
//   - If pend[lock_addr] is at maximum, the count is unchanged, the lock is dropped and
//     lock_err <= 1. lock_err holds until reset.
//   - lock_full = (pend[lock_addr] == max).
//   Simultaneous lock and write to the same address
//   - The count is unchanged: one release plus one acquire. The data write still occurs.
//   - If the count is 0, the net result is +1 and the data write still occurs.
//   - If the count is at max, the net result is unchanged and no error is raised.
//   Read (combinational, zero latency)
//   - Without bypass: rd_data[p] = reg[a], rd_busy[p] = (pend[a] != 0), where a = rd_addr slice p.
//   - With BYPASS=1, when wr_en and wr_addr == a:
//     - rd_data[p] = wr_data.
//     - rd_busy[p] = (pend_next[a] != 0), where pend_next is the post-edge count including
//       any same-cycle lock.
//   - With BYPASS=0, reads see only registered state; written data appears the cycle after the edge.
//   ZERO_REG=1
//   - Address 0 always gives rd_data=0 and rd_busy=0.
//   - wr_en and lock_en targeting address 0 are ignored: no count change, no lock_err.
//   - lock_full is 0 for address 0.
//   Addresses
//   - Addresses >= WORDS (non-power-of-2 WORDS) read 0, are never busy, and are ignored
//     on write and lock.
//   Reset mid-operation
//   - Asserting clr discards all pending state immediately.
//   - The first edge after release behaves as after power-up.
// STRUCTURE
//   Shared defines file (`include)
//   - Default BITS/WORDS, and register-index constants used by the decoder.
//   Sub-modules
//   - pending_counter: one saturating PEND_BITS up/down counter per register with
//     inc/dec/full.
//   - Data storage reuses the existing en/clr `register` cell in a generate loop.
//     clr is inverted at that boundary.
//   - Read muxes and bypass comparators are generated per READ_PORTS.
// TESTING
//   1. Write 853->r11, 888->r15 with no locks; read r11/r15 on ports 0/1
//      -> 853/888, busy=00.
//   2. Lock r4; next cycle read r4 -> busy=1. Write 124->r4 with BYPASS=1, read
//      r4 same cycle -> data=124, busy=0.
//   3. Lock r7 three times (PEND_BITS=2) -> lock_full=1.
//      A fourth lock -> count stays 3, lock_err=1. Three writes -> busy clears
//      only after the third.
//   4. Same cycle: lock r5 and write 42->r5 with count=1 -> count stays 1,
//      busy=1, data=42.
//   5. ZERO_REG=1: write 999->r0 and lock r0 -> r0 reads 0, busy=0, lock_err=0.
//   6. Lock r3 and write r9, then drop clr mid-cycle -> immediate rd_data=0,
//      busy=0, lock_err=0 with no clock edge.

Source files
------------

// File: rtl/scoreboard_register_file_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// the pending-counter operation encoding and the register validity helper.
package scoreboard_register_file_pkg;

    localparam int unsigned DEFAULT_WORDS      = 16;
    localparam int unsigned DEFAULT_BITS       = 32;
    localparam int unsigned DEFAULT_READ_PORTS = 2;
    localparam int unsigned DEFAULT_PEND_BITS  = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A register index holds state only if it exists and is not the
    // hard-wired zero register.
    function automatic logic reg_writable(input int unsigned idx,
                                          input int unsigned words,
                                          input logic        zero_reg);
        return (idx < words) && !(zero_reg && (idx == 0));
    endfunction

endpackage

// File: rtl/scoreboard_register_file_pending_counter.sv
// Saturating per-register pending-write counter.
// Ports:
//   clk      clock
//   clr      asynchronous reset, active-low
//   i_inc    lock (acquire) request
//   i_dec    writeback (release) request
//   o_count  current registered count
//   o_next   count after the coming edge (drives bypassed busy)
//   o_full   count is at its maximum
//   o_drop   a lock is being dropped because the counter is saturated
module pending_counter
    import scoreboard_register_file_pkg::*;
#(
    parameter int unsigned PEND_BITS = DEFAULT_PEND_BITS
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 i_inc,
    input  logic                 i_dec,
    output logic [PEND_BITS-1:0] o_count,
    output logic [PEND_BITS-1:0] o_next,
    output logic                 o_full,
    output logic                 o_drop
);

    logic [PEND_BITS-1:0] r_count;
    cnt_op_e              w_op;

    assign o_count = r_count;
    assign o_full  = (r_count == '1);

    // Acquire+release together cancel, except from zero where the release
    // has nothing to release and the acquire still lands. At max the pair
    // also cancels, so no drop is reported.
    always_comb begin
        w_op   = CNT_HOLD;
        o_drop = 1'b0;
        if (i_inc && i_dec) begin
            w_op = (r_count == '0) ? CNT_INC : CNT_HOLD;
        end else if (i_inc) begin
            if (o_full) o_drop = 1'b1;
            else        w_op   = CNT_INC;
        end else if (i_dec && (r_count != '0)) begin
            w_op = CNT_DEC;
        end
        case (w_op)
            CNT_INC: o_next = r_count + 1'b1;
            CNT_DEC: o_next = r_count - 1'b1;
            default: o_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_count <= '0;
        else      r_count <= o_next;
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-read-port register file with per-register pending-write scoreboard
// and same-cycle write-to-read bypass.
// Ports:
//   clk        clock
//   clr        asynchronous reset, active-low
//   wr_en      writeback strobe, wr_addr/wr_data its register and value
//   lock_en    issue strobe, lock_addr the destination made pending
//   rd_addr    packed read addresses, port p at slice p
//   rd_data    packed combinational read data
//   rd_busy    per-port: operand has an outstanding write
//   lock_full  counter at lock_addr is saturated
//   lock_err   sticky: a lock was dropped at saturation
module scoreboard_register_file
    import scoreboard_register_file_pkg::*;
#(
    parameter int unsigned WORDS        = DEFAULT_WORDS,
    parameter int unsigned BITS         = DEFAULT_BITS,
    parameter int unsigned READ_PORTS   = DEFAULT_READ_PORTS,
    parameter int unsigned ZERO_REG     = 1,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned PEND_BITS    = DEFAULT_PEND_BITS,
    parameter int unsigned ADDRESS_BITS = $clog2(WORDS)
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               wr_en,
    input  logic [ADDRESS_BITS-1:0]            wr_addr,
    input  logic [BITS-1:0]                    wr_data,
    input  logic                               lock_en,
    input  logic [ADDRESS_BITS-1:0]            lock_addr,
    input  logic [READ_PORTS*ADDRESS_BITS-1:0] rd_addr,
    output logic [READ_PORTS*BITS-1:0]         rd_data,
    output logic [READ_PORTS-1:0]              rd_busy,
    output logic                               lock_full,
    output logic                               lock_err
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [BITS-1:0]      r_mem   [WORDS];
    logic [PEND_BITS-1:0] w_count [WORDS];
    logic [PEND_BITS-1:0] w_next  [WORDS];
    logic [WORDS-1:0]     w_wr_hit;
    logic [WORDS-1:0]     w_lock_sel;
    logic [WORDS-1:0]     w_lock_hit;
    logic [WORDS-1:0]     w_full;
    logic [WORDS-1:0]     w_drop;
    logic                 r_lock_err;

    // Address decode; the zero register and out-of-range addresses never
    // match, so they are ignored for write, lock and lock_full alike.
    always_comb begin
        w_wr_hit   = '0;
        w_lock_sel = '0;
        w_lock_hit = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            w_wr_hit[i]   = wr_en && reg_writable(i, WORDS, ZERO_EN) &&
                            (wr_addr == ADDRESS_BITS'(i));
            w_lock_sel[i] = reg_writable(i, WORDS, ZERO_EN) &&
                            (lock_addr == ADDRESS_BITS'(i));
            w_lock_hit[i] = lock_en && w_lock_sel[i];
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_pend
        pending_counter #(
            .PEND_BITS(PEND_BITS)
        ) u_pend (
            .clk     (clk),
            .clr     (clr),
            .i_inc   (w_lock_hit[g]),
            .i_dec   (w_wr_hit[g]),
            .o_count (w_count[g]),
            .o_next  (w_next[g]),
            .o_full  (w_full[g]),
            .o_drop  (w_drop[g])
        );
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < WORDS; i++) r_mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (w_wr_hit[i]) r_mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_lock_err <= 1'b0;
        else      r_lock_err <= r_lock_err | (|w_drop);
    end

    assign lock_full = |(w_lock_sel & w_full);
    assign lock_err  = r_lock_err;

    // Read ports are gated by clr so a write presented during reset cannot
    // leak through the bypass path.
    always_comb begin
        logic [ADDRESS_BITS-1:0] w_a;
        rd_data = '0;
        rd_busy = '0;
        w_a     = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            w_a = rd_addr[p*ADDRESS_BITS +: ADDRESS_BITS];
            if (clr && reg_writable(32'(w_a), WORDS, ZERO_EN)) begin
                rd_data[p*BITS +: BITS] = r_mem[w_a];
                rd_busy[p]              = (w_count[w_a] != '0);
                if ((BYPASS != 0) && wr_en && (wr_addr == w_a)) begin
                    rd_data[p*BITS +: BITS] = wr_data;
                    rd_busy[p]              = (w_next[w_a] != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        lock_en = 1'b0;
    logic [3:0]  lock_addr = '0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        lock_full;
    logic        lock_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [1:0]  busy;
        logic        full;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    scoreboard_register_file #(
        .WORDS      (16),
        .BITS       (32),
        .READ_PORTS (2),
        .ZERO_REG   (1),
        .BYPASS     (1),
        .PEND_BITS  (2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .lock_full (lock_full),
        .lock_err  (lock_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge and queue the
    // outputs expected while those inputs are applied.
    task automatic cyc(input logic c, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic le, input logic [3:0] la,
                       input logic [3:0] a0, input logic [3:0] a1, input string nm,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb, input logic ef, input logic ee);
        @(posedge clk);
        #1;
        clr       = c;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        lock_en   = le;
        lock_addr = la;
        rd_addr   = {a1, a0};
        q.push_back('{nm, {e1, e0}, eb, ef, ee});
    endtask

    // Monitor: compares on the falling edge whenever an expectation is queued.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_cmp++;
            if (rd_data !== m_e.data || rd_busy !== m_e.busy ||
                lock_full !== m_e.full || lock_err !== m_e.err) begin
                n_err++;
                $display("FAIL %s: got data=%h busy=%b full=%b err=%b, expected data=%h busy=%b full=%b err=%b",
                         m_e.name, rd_data, rd_busy, lock_full, lock_err,
                         m_e.data, m_e.busy, m_e.full, m_e.err);
            end
        end
    end

    initial begin
        //   clr we wa   wd    le la  a0  a1  name            d0   d1   busy   full  err
        cyc(0, 1, 11,  5,    0, 0, 11, 15, "reset",        0,   0,   2'b00, 0, 0);
        cyc(1, 1, 11,  853,  0, 0, 11, 15, "wr11_bypass",  853, 0,   2'b00, 0, 0);
        cyc(1, 1, 15,  888,  0, 0, 11, 15, "wr15_bypass",  853, 888, 2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 0, 11, 15, "rd11_15",      853, 888, 2'b00, 0, 0);
        cyc(1, 0, 0,   0,    1, 4, 4,  11, "lock4_issue",  0,   853, 2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 4, 4,  0,  "r4_busy",      0,   0,   2'b01, 0, 0);
        cyc(1, 1, 4,   124,  0, 4, 4,  4,  "wr4_bypass",   124, 124, 2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 4, 4,  15, "r4_after",     124, 888, 2'b00, 0, 0);
        cyc(1, 1, 0,   999,  1, 0, 0,  11, "zero_wr_lock", 0,   853, 2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 0, 0,  0,  "zero_after",   0,   0,   2'b00, 0, 0);
        cyc(1, 0, 0,   0,    1, 7, 7,  7,  "lock7_a",      0,   0,   2'b00, 0, 0);
        cyc(1, 0, 0,   0,    1, 7, 7,  7,  "lock7_b",      0,   0,   2'b11, 0, 0);
        cyc(1, 0, 0,   0,    1, 7, 7,  7,  "lock7_c",      0,   0,   2'b11, 0, 0);
        cyc(1, 0, 0,   0,    0, 7, 7,  7,  "r7_full",      0,   0,   2'b11, 1, 0);
        cyc(1, 0, 0,   0,    1, 7, 7,  7,  "lock_at_max",  0,   0,   2'b11, 1, 0);
        cyc(1, 0, 0,   0,    0, 7, 7,  7,  "lock_err",     0,   0,   2'b11, 1, 1);
        cyc(1, 1, 7,   1,    0, 7, 7,  7,  "rel7_1",       1,   1,   2'b11, 1, 1);
        cyc(1, 1, 7,   2,    0, 7, 7,  7,  "rel7_2",       2,   2,   2'b11, 0, 1);
        cyc(1, 1, 7,   3,    0, 7, 7,  7,  "rel7_3",       3,   3,   2'b00, 0, 1);
        cyc(1, 0, 0,   0,    0, 7, 7,  7,  "r7_idle",      3,   3,   2'b00, 0, 1);
        cyc(1, 0, 0,   0,    1, 5, 5,  7,  "lock5",        0,   3,   2'b00, 0, 1);
        cyc(1, 1, 5,   42,   1, 5, 5,  5,  "lockwr5_c1",   42,  42,  2'b11, 0, 1);
        cyc(1, 0, 0,   0,    0, 5, 5,  5,  "r5_after",     42,  42,  2'b11, 0, 1);
        cyc(1, 1, 9,   77,   1, 9, 9,  5,  "lockwr9_c0",   77,  42,  2'b11, 0, 1);
        cyc(1, 0, 0,   0,    0, 9, 9,  9,  "r9_after",     77,  77,  2'b11, 0, 1);
        cyc(1, 1, 9,   55,   1, 3, 3,  9,  "lock3_wr9",    0,   55,  2'b00, 0, 1);
        cyc(1, 0, 0,   0,    0, 3, 3,  9,  "r3_busy",      0,   55,  2'b01, 0, 1);
        cyc(0, 1, 9,   66,   1, 3, 3,  9,  "clr_mid",      0,   0,   2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 3, 3,  9,  "post_reset",   0,   0,   2'b00, 0, 0);
        cyc(1, 0, 0,   0,    1, 3, 3,  9,  "relock3",      0,   0,   2'b00, 0, 0);
        cyc(1, 0, 0,   0,    0, 3, 3,  9,  "relock3_busy", 0,   0,   2'b01, 0, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
